// File: rtl/dma_uart_pkg.sv
// Shared types and helpers for the DMA-to-UART transmit framer.
// Contents: FSM state encoding, default frame start marker, and the
// data-bytes-per-word helper used to size the framer datapath.
package dma_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ADDR,
        ST_DATA,
        ST_CSUM
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Number of bytes needed to carry a w-bit word.
    function automatic int unsigned nb_bytes(input int unsigned w);
        return (w + 32'd7) / 32'd8;
    endfunction

endpackage

// File: rtl/dma_tx_fifo.sv
// Frame FIFO for the transmit framer.
// Ports: clk, reset_n (async active-low), push/wr_data write side,
// pop/rd_data read side (rd_data shows the head entry), full/empty
// flags (registered), empty_nxt_c (combinational next-cycle empty).
// Push while full and pop while empty are ignored.
module dma_tx_fifo #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             empty_nxt_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push     = push && !full;
    assign do_pop      = pop && !empty;
    assign rd_data     = mem[rd_ptr];
    assign empty_nxt_c = (count_d == '0);

    // Occupancy update; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count;
        case ({do_push, do_pop})
            2'b10:   count_d = count + CW'(1);
            2'b01:   count_d = count - CW'(1);
            default: count_d = count;
        endcase
    end

    // Pointers and flags; pointer wrap is free because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_d;
            full  <= (count_d == CW'(DEPTH));
            empty <= (count_d == '0);
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/dma_uart_tx_framer.sv
// DMA-to-UART transmit framer.
// Each write (we, dat_w, dat_addr) is queued and later sent to the UART as
// SYNC_BYTE, address byte, then ceil(DATA_W/8) data bytes LSB first.
// Optional feature macro DMA_TX_CHECKSUM_EN appends an XOR checksum byte
// covering the address and data bytes.
// Ports: clk, reset_n (async active-low); we/dat_w/dat_addr write side with
// full and sticky overflow; tx_data/tx_valid/tx_ready byte stream; busy;
// frames_sent (wrapping count of completed frames).
module dma_uart_tx_framer
    import dma_uart_pkg::*;
#(
    parameter int unsigned DATA_W    = 18,
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned DEPTH     = 8,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [DATA_W-1:0] dat_w,
    input  logic [ADDR_W-1:0] dat_addr,
    output logic              full,
    output logic              overflow,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic [15:0]       frames_sent
);

    localparam int unsigned NB     = nb_bytes(DATA_W);
    localparam int unsigned PAD_W  = NB * 8;
    localparam int unsigned IDX_W  = $clog2(NB) + 1;
    localparam int unsigned HOLD_W = ADDR_W + DATA_W;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [7:0]          tx_data_d;
    logic                tx_valid_d;
    logic [15:0]         frames_d;
    logic                busy_d;
    logic                pop_c;
    logic                accept;
    logic [HOLD_W-1:0]   fifo_rd_data;
    logic                fifo_empty;
    logic                fifo_empty_nxt_c;
    logic [PAD_W-1:0]    data_pad;
    logic [7:0]          addr_byte;
    logic [7:0]          next_byte;
`ifdef DMA_TX_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    // Select byte 'sel' of the zero-padded data word.
    function automatic logic [7:0] data_byte(input logic [PAD_W-1:0] d,
                                             input logic [IDX_W-1:0] sel);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < int'(NB); i++) begin
            if (IDX_W'(i) == sel) r = d[8*i +: 8];
        end
        return r;
    endfunction

    dma_tx_fifo #(
        .WIDTH (HOLD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (we),
        .wr_data     ({dat_addr, dat_w}),
        .pop         (pop_c),
        .rd_data     (fifo_rd_data),
        .full        (full),
        .empty       (fifo_empty),
        .empty_nxt_c (fifo_empty_nxt_c)
    );

    assign accept    = tx_valid && tx_ready;
    assign data_pad  = PAD_W'(hold_q[DATA_W-1:0]);
    assign addr_byte = 8'(hold_q[HOLD_W-1:DATA_W]);
    assign next_byte = data_byte(data_pad, idx_q + IDX_W'(1));

    // Next state and next registered outputs; the byte for the following
    // state is loaded on the accepting handshake so tx_data is a flop.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data;
        tx_valid_d = tx_valid;
        frames_d   = frames_sent;
        pop_c      = 1'b0;
`ifdef DMA_TX_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c      = 1'b1;
                    hold_d     = fifo_rd_data;
                    state_d    = ST_SYNC;
                    tx_valid_d = 1'b1;
                    tx_data_d  = SYNC_BYTE;
                end
            end
            ST_SYNC: begin
                if (accept) begin
                    state_d   = ST_ADDR;
                    tx_data_d = addr_byte;
`ifdef DMA_TX_CHECKSUM_EN
                    csum_d    = addr_byte;
`endif
                end
            end
            ST_ADDR: begin
                if (accept) begin
                    state_d   = ST_DATA;
                    idx_d     = '0;
                    tx_data_d = data_byte(data_pad, IDX_W'(0));
`ifdef DMA_TX_CHECKSUM_EN
                    csum_d    = csum_q ^ data_byte(data_pad, IDX_W'(0));
`endif
                end
            end
            ST_DATA: begin
                if (accept) begin
                    if (idx_q == IDX_W'(NB - 1)) begin
`ifdef DMA_TX_CHECKSUM_EN
                        state_d    = ST_CSUM;
                        tx_data_d  = csum_q;
`else
                        state_d    = ST_IDLE;
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'h00;
                        frames_d   = frames_sent + 16'd1;
`endif
                    end else begin
                        idx_d     = idx_q + IDX_W'(1);
                        tx_data_d = next_byte;
`ifdef DMA_TX_CHECKSUM_EN
                        csum_d    = csum_q ^ next_byte;
`endif
                    end
                end
            end
`ifdef DMA_TX_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                    tx_data_d  = 8'h00;
                    frames_d   = frames_sent + 16'd1;
                end
            end
`endif
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
                tx_data_d  = 8'h00;
            end
        endcase
        busy_d = !fifo_empty_nxt_c || (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            idx_q       <= '0;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            frames_sent <= 16'h0000;
            busy        <= 1'b0;
            overflow    <= 1'b0;
`ifdef DMA_TX_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            idx_q       <= idx_d;
            tx_data     <= tx_data_d;
            tx_valid    <= tx_valid_d;
            frames_sent <= frames_d;
            busy        <= busy_d;
            if (we && full) overflow <= 1'b1;
`ifdef DMA_TX_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_dma_uart_tx_framer.sv
// Self-checking bench for dma_uart_tx_framer: an 18-bit/7-bit instance and
// a 32-bit/8-bit instance. Expected bytes go into per-instance queues; a
// monitor per instance pops and compares on every tx handshake.
module tb_dma_uart_tx_framer;

    typedef struct packed {
        logic [7:0] b;
        logic       first;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        we_a = 1'b0;
    logic [17:0] dw_a = '0;
    logic [6:0]  da_a = '0;
    logic        rdy_a = 1'b0;
    logic        full_a, ovf_a, txv_a, busy_a;
    logic [7:0]  txd_a;
    logic [15:0] fs_a;

    logic        we_b = 1'b0;
    logic [31:0] dw_b = '0;
    logic [7:0]  da_b = '0;
    logic        rdy_b = 1'b0;
    logic        full_b, ovf_b, txv_b, busy_b;
    logic [7:0]  txd_b;
    logic [15:0] fs_b;

    int errors = 0;
    int checks = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    int cyc_a = 0;
    int end_a = 0;
    int gap_a = 0;

    always #5 clk = ~clk;

    dma_uart_tx_framer u_dut_a (
        .clk(clk), .reset_n(reset_n), .we(we_a), .dat_w(dw_a), .dat_addr(da_a),
        .full(full_a), .overflow(ovf_a), .tx_data(txd_a), .tx_valid(txv_a),
        .tx_ready(rdy_a), .busy(busy_a), .frames_sent(fs_a)
    );

    dma_uart_tx_framer #(.DATA_W(32), .ADDR_W(8), .DEPTH(4)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .we(we_b), .dat_w(dw_b), .dat_addr(da_b),
        .full(full_b), .overflow(ovf_b), .tx_data(txd_b), .tx_valid(txv_b),
        .tx_ready(rdy_b), .busy(busy_b), .frames_sent(fs_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] b, input logic f, input logic l);
        exp_t e;
        e.b = b; e.first = f; e.last = l;
        return e;
    endfunction

    // Reference framing of an 18-bit word with a 7-bit address.
    task automatic expect_frame_a(input logic [17:0] d, input logic [6:0] ad);
        logic [7:0] b [4];
        logic [7:0] cs;
        b[0] = {1'b0, ad};
        b[1] = d[7:0];
        b[2] = d[15:8];
        b[3] = {6'b0, d[17:16]};
        cs = 8'h00;
        q_a.push_back(mk(8'hA5, 1'b1, 1'b0));
        for (int i = 0; i < 4; i++) begin
            cs = cs ^ b[i];
`ifdef DMA_TX_CHECKSUM_EN
            q_a.push_back(mk(b[i], 1'b0, 1'b0));
`else
            q_a.push_back(mk(b[i], 1'b0, i == 3));
`endif
        end
`ifdef DMA_TX_CHECKSUM_EN
        q_a.push_back(mk(cs, 1'b0, 1'b1));
`endif
    endtask

    task automatic write_a(input logic [17:0] d, input logic [6:0] ad);
        we_a = 1'b1; dw_a = d; da_a = ad;
        @(posedge clk); #1;
        we_a = 1'b0;
    endtask

    task automatic drain_a();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (q_a.size() == 0 && !txv_a) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_a: %0d bytes still outstanding, required 0", q_a.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_valid_a(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (txv_a) seen = 1'b1;
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    // Monitor for instance A: byte order, hold-while-stalled, inter-frame gap.
    initial begin
        logic       stall = 1'b0;
        logic [7:0] stall_d = 8'h00;
        exp_t       e;
        forever begin
            @(negedge clk);
            cyc_a++;
            if (!reset_n) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("hold_valid_a", 32'(txv_a), 32'd1);
                    chk("hold_data_a", 32'(txd_a), 32'(stall_d));
                end
                if (txv_a && rdy_a) begin
                    if (q_a.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_byte_a: got %h, required no byte", txd_a);
                    end else begin
                        e = q_a.pop_front();
                        chk("byte_a", 32'(txd_a), 32'(e.b));
                        if (e.first) gap_a = cyc_a - end_a;
                        if (e.last)  end_a = cyc_a;
                    end
                end
                stall   = txv_a && !rdy_a;
                stall_d = txd_a;
            end
        end
    end

    // Monitor for instance B.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && txv_b && rdy_b) begin
                if (q_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_byte_b: got %h, required no byte", txd_b);
                end else begin
                    e = q_b.pop_front();
                    chk("byte_b", 32'(txd_b), 32'(e.b));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_txv_a", 32'(txv_a), 32'd0);
        chk("rst_txd_a", 32'(txd_a), 32'd0);
        chk("rst_full_a", 32'(full_a), 32'd0);
        chk("rst_ovf_a", 32'(ovf_a), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_fs_a", 32'(fs_a), 32'd0);
        chk("rst_txv_b", 32'(txv_b), 32'd0);
        chk("rst_fs_b", 32'(fs_b), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        @(posedge clk); #1;

        // Basic frame 34133 @ 120, plus first-byte latency.
        q_a.push_back(mk(8'hA5, 1'b1, 1'b0));
        q_a.push_back(mk(8'h78, 1'b0, 1'b0));
        q_a.push_back(mk(8'h55, 1'b0, 1'b0));
        q_a.push_back(mk(8'h85, 1'b0, 1'b0));
`ifdef DMA_TX_CHECKSUM_EN
        q_a.push_back(mk(8'h00, 1'b0, 1'b0));
        q_a.push_back(mk(8'hA8, 1'b0, 1'b1));
`else
        q_a.push_back(mk(8'h00, 1'b0, 1'b1));
`endif
        write_a(18'd34133, 7'd120);
        @(negedge clk);
        chk("lat_n1_txv", 32'(txv_a), 32'd0);
        chk("lat_n1_busy", 32'(busy_a), 32'd1);
        @(negedge clk);
        chk("lat_n2_txv", 32'(txv_a), 32'd1);
        chk("lat_n2_txd", 32'(txd_a), 32'hA5);
        drain_a();
        chk("fs_after_1", 32'(fs_a), 32'd1);
        chk("busy_idle", 32'(busy_a), 32'd0);

        // Stall five cycles on the address byte.
        rdy_a = 1'b0;
        expect_frame_a(18'd34133, 7'd120);
        write_a(18'd34133, 7'd120);
        wait_valid_a("stall_wait_valid");
        @(posedge clk); #1;
        rdy_a = 1'b1;
        @(posedge clk); #1;
        rdy_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_txv", 32'(txv_a), 32'd1);
            chk("stall_txd", 32'(txd_a), 32'h78);
            @(posedge clk); #1;
        end
        rdy_a = 1'b1;
        drain_a();
        chk("fs_after_2", 32'(fs_a), 32'd2);

        // Overflow: one frame in flight, then 9 back-to-back writes.
        rdy_a = 1'b0;
        expect_frame_a(18'h3FFFF, 7'h7F);
        write_a(18'h3FFFF, 7'h7F);
        repeat (3) begin @(posedge clk); #1; end
        for (int k = 1; k <= 9; k++) begin
            logic [17:0] d;
            logic [6:0]  ad;
            d  = 18'(k * 32'h0A5C3 + 7);
            ad = 7'(k + 3);
            if (k <= 8) expect_frame_a(d, ad);
            write_a(d, ad);
            chk($sformatf("full_after_w%0d", k), 32'(full_a), 32'(k >= 8));
            chk($sformatf("ovf_after_w%0d", k), 32'(ovf_a), 32'(k == 9));
        end
        rdy_a = 1'b1;
        drain_a();
        chk("fs_after_burst", 32'(fs_a), 32'd11);
        chk("full_after_burst", 32'(full_a), 32'd0);
        chk("ovf_sticky", 32'(ovf_a), 32'd1);

        // Reset while presenting a data byte.
        rdy_a = 1'b0;
        expect_frame_a(18'h2ABCD, 7'h33);
        write_a(18'h2ABCD, 7'h33);
        wait_valid_a("rst_wait_valid");
        @(posedge clk); #1;
        rdy_a = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rdy_a = 1'b0;
        @(negedge clk);
        chk("in_data_txd", 32'(txd_a), 32'hCD);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("arst_txv", 32'(txv_a), 32'd0);
        chk("arst_txd", 32'(txd_a), 32'd0);
        chk("arst_busy", 32'(busy_a), 32'd0);
        chk("arst_ovf", 32'(ovf_a), 32'd0);
        chk("arst_fs", 32'(fs_a), 32'd0);
        chk("arst_full", 32'(full_a), 32'd0);
        q_a.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        rdy_a = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        chk("post_rst_txv", 32'(txv_a), 32'd0);
        chk("post_rst_busy", 32'(busy_a), 32'd0);

        // Two back-to-back frames: exactly one idle cycle between them.
        gap_a = -1;
        expect_frame_a(18'h00001, 7'h01);
        expect_frame_a(18'h10203, 7'h02);
        write_a(18'h00001, 7'h01);
        write_a(18'h10203, 7'h02);
        drain_a();
        chk("b2b_gap", 32'(gap_a), 32'd2);
        chk("fs_b2b", 32'(fs_a), 32'd2);

        // Wide instance: 32'h11223344 @ 8'h05.
        q_b.push_back(mk(8'hA5, 1'b1, 1'b0));
        q_b.push_back(mk(8'h05, 1'b0, 1'b0));
        q_b.push_back(mk(8'h44, 1'b0, 1'b0));
        q_b.push_back(mk(8'h33, 1'b0, 1'b0));
        q_b.push_back(mk(8'h22, 1'b0, 1'b0));
`ifdef DMA_TX_CHECKSUM_EN
        q_b.push_back(mk(8'h11, 1'b0, 1'b0));
        q_b.push_back(mk(8'h41, 1'b0, 1'b1));
`else
        q_b.push_back(mk(8'h11, 1'b0, 1'b1));
`endif
        we_b = 1'b1; dw_b = 32'h11223344; da_b = 8'h05;
        @(posedge clk); #1;
        we_b = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (q_b.size() == 0 && !txv_b) done = 1'b1;
        end
        chk("drain_b", 32'(done), 32'd1);
        chk("fs_b", 32'(fs_b), 32'd1);
        chk("busy_b_idle", 32'(busy_b), 32'd0);
        chk("ovf_b", 32'(ovf_b), 32'd0);
        chk("full_b", 32'(full_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
